// File: rtl/rx_parity_check.sv
// ---------------------------------------------------------------------------
// rx_parity_check
//   UART receiver for 8E1 frames: start(0), 8 data bits LSB first,
//   one even-parity bit, one stop(1). The data byte and the error flags are
//   loaded one cycle after the stop-bit sample, with a one-cycle Rx_valid
//   pulse. Error frames still produce Rx_valid; the flags qualify them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit period (even, >= 4)
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   Rx_line    : asynchronous serial input, idle high
//   Rx_data    : last received byte, held until the next Rx_valid
//   Rx_valid   : one-cycle pulse per completed frame
//   Parity_err : parity sample differs from XOR of Rx_data
//   Frame_err  : stop bit sampled low
//   Busy       : receiver FSM is not idle
// ---------------------------------------------------------------------------
module rx_parity_check #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx_line,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    output logic       Parity_err,
    output logic       Frame_err,
    output logic       Busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Compare values for the bit-period counter. The first sample lands half
    // a bit after the falling edge; every later sample is one full bit later.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Synchronizer and edge-detect copy; reset high so that a line that is
    // already idle does not look like a falling edge after reset.
    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_dly_q;

    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          par_q,    par_d;
    logic [7:0]    data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          perr_q,   perr_d;
    logic          ferr_q,   ferr_d;

    logic          fall;
    logic          cnt_half;
    logic          cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= Rx_line;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
        end
    end

    // Only a genuine 1->0 transition starts a frame; a line held low (break)
    // never re-triggers until it has gone high again.
    assign fall     = rx_dly_q & ~rx_s_q;
    assign cnt_half = (cnt_q == HALF_M1);
    assign cnt_full = (cnt_q == FULL_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (fall) begin
                    state_d = S_START;
                end
            end

            // Mid-start check: a line already back high is a glitch, drop it
            // without touching the output registers.
            S_START: begin
                if (cnt_half) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (cnt_full) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Frame completes at the mid-stop sample rather than the end of
            // the stop bit, so the FSM is idle in time for a back-to-back
            // start edge.
            S_STOP: begin
                if (cnt_full) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    perr_d  = par_q ^ (^shift_q);
                    ferr_d  = ~rx_s_q;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Rx_data    = data_q;
    assign Rx_valid   = valid_q;
    assign Parity_err = perr_q;
    assign Frame_err  = ferr_q;
    assign Busy       = (state_q != S_IDLE);

endmodule
